// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache fetch slice.
//   state_t   : fetch controller states (IDLE, REFILL)
//   NOP_INSTR : instruction presented to decode while the fetch is stalled
package icache_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped tag/valid/data storage, one 32-bit word per line.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset (valid bits only)
//   clr               : flash-clear of every valid bit; wins over a same-edge write
//   rd_idx            : combinational read index
//   rd_valid/tag/data : contents of the addressed line
//   wr_en/idx/tag/data: line fill, sets the valid bit unless clr is high
module icache_array
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = 4,
  parameter int TAG_W     = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (clr) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache_fetch.sv
// Instruction-fetch front end with a direct-mapped, one-word-per-line cache.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   pc             : fetch address
//   instr_f        : fetched instruction (NOP while stalled)
//   icache_stall   : high whenever instr_f is not valid
//   inv            : pulse clearing every line
//   mem_req/addr   : refill request and word-aligned address (zero when idle)
//   mem_rdata/ready: refill data and its one-cycle completion strobe
//   miss_count     : saturating miss counter
module icache_fetch
  import icache_pkg::*;
#(
  parameter int NUM_LINES  = 16,
  parameter int MISS_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           pc,
  output logic [31:0]           instr_f,
  output logic                  icache_stall,
  input  logic                  inv,
  output logic                  mem_req,
  output logic [31:0]           mem_addr,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic [MISS_CNT_W-1:0] miss_count
);

  localparam int IW    = $clog2(NUM_LINES);
  localparam int TAG_W = 32 - IW - 2;

  function automatic logic [MISS_CNT_W-1:0] sat_inc(input logic [MISS_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t                state_q, state_d;
  logic [31:2]           miss_addr_q;
  logic [MISS_CNT_W-1:0] miss_count_q;

  logic                  rd_valid;
  logic [TAG_W-1:0]      rd_tag;
  logic [31:0]           rd_data;
  logic                  hit;
  logic                  miss_start;
  logic                  fill;

  // Byte offset never selects anything: every line holds one whole word.
  logic unused_offset;
  assign unused_offset = ^pc[1:0];

  icache_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IW),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst      (reset),
    .clr      (inv),
    .rd_idx   (pc[IW+1:2]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill),
    .wr_idx   (miss_addr_q[IW+1:2]),
    .wr_tag   (miss_addr_q[31:IW+2]),
    .wr_data  (mem_rdata)
  );

  assign hit = rd_valid && (rd_tag == pc[31:IW+2]);

  always_comb begin
    state_d      = state_q;
    instr_f      = NOP_INSTR;
    icache_stall = 1'b1;
    mem_req      = 1'b0;
    mem_addr     = 32'h0;
    miss_start   = 1'b0;
    fill         = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          instr_f      = rd_data;
          icache_stall = 1'b0;
        end else begin
          miss_start = 1'b1;
          state_d    = REFILL;
        end
      end
      REFILL: begin
        // The request is held until completion; inv only affects the valid
        // bits, so a same-edge inv leaves the filled line invalid.
        mem_req  = 1'b1;
        mem_addr = {miss_addr_q, 2'b00};
        if (mem_ready) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      miss_addr_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (miss_start) begin
        miss_addr_q  <= pc[31:2];
        miss_count_q <= sat_inc(miss_count_q);
      end
    end
  end

  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache_fetch.sv
// Bench for icache_fetch: directed scenarios followed by randomized fetches,
// checked against a line-level cache model and a simple memory function.
module tb_icache_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        inv;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  logic [31:0] instr_f, mem_addr;
  logic        icache_stall, mem_req;
  logic [15:0] miss_count;

  logic [31:0] instr_f2, mem_addr2;
  logic        icache_stall2, mem_req2;
  logic [1:0]  miss_count2;

  int n_tests = 0;
  int n_fail  = 0;
  int stall_seen;
  int mcount;

  bit          mv [16];
  logic [25:0] mt [16];
  logic [31:0] md [16];

  always #5 clk = ~clk;

  icache_fetch #(.NUM_LINES(16), .MISS_CNT_W(16)) dut (
    .clk(clk), .reset(reset), .pc(pc), .instr_f(instr_f),
    .icache_stall(icache_stall), .inv(inv), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .miss_count(miss_count)
  );

  icache_fetch #(.NUM_LINES(16), .MISS_CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .pc(pc), .instr_f(instr_f2),
    .icache_stall(icache_stall2), .inv(inv), .mem_req(mem_req2),
    .mem_addr(mem_addr2), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .miss_count(miss_count2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic int sat2(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
  endtask

  // One IDLE lookup cycle; returns whether the model predicts a hit.
  task automatic lookup(input logic [31:0] a, input bit do_inv, input bit late_ready,
                        output bit was_hit);
    int idx;
    bit h;
    @(negedge clk);
    reset     = 1'b0;
    pc        = a;
    inv       = do_inv;
    mem_ready = late_ready;
    mem_rdata = 32'hBAD0_0000 ^ a;
    #1;
    idx = int'(a[5:2]);
    h   = mv[idx] && (mt[idx] == a[31:6]);
    chk("miss_count", 32'(miss_count), 32'(mcount));
    chk("miss_count_sat", 32'(miss_count2), 32'(sat2(mcount)));
    if (icache_stall) stall_seen++;
    if (h) begin
      chk("hit_stall", 32'(icache_stall), 32'd0);
      chk("hit_instr", instr_f, md[idx]);
    end else begin
      chk("miss_stall", 32'(icache_stall), 32'd1);
      chk("miss_instr", instr_f, 32'h0);
      mcount++;
    end
    chk("idle_mem_req", 32'(mem_req), 32'd0);
    chk("idle_mem_addr", mem_addr, 32'h0);
    if (do_inv) model_clear();
    was_hit = h;
  endtask

  // REFILL phase: memory answers after lat cycles of waiting.
  task automatic refill(input logic [31:0] a, input int lat, input bit inv_last,
                        input bit inv_mid);
    logic [31:0] aa;
    int idx;
    aa  = {a[31:2], 2'b00};
    idx = int'(a[5:2]);
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      mem_ready = (c == lat);
      mem_rdata = (c == lat) ? mem_word(aa) : 32'hDEAD_BEEF;
      inv       = (c == lat) ? inv_last : (inv_mid && c == 0);
      pc        = $urandom;
      #1;
      if (icache_stall) stall_seen++;
      chk("refill_req", 32'(mem_req), 32'd1);
      chk("refill_addr", mem_addr, aa);
      chk("refill_stall", 32'(icache_stall), 32'd1);
      chk("refill_instr", instr_f, 32'h0);
      if (inv) model_clear();
      if (c == lat && !inv) begin
        mv[idx] = 1'b1;
        mt[idx] = aa[31:6];
        md[idx] = mem_word(aa);
      end
    end
  endtask

  task automatic fetch(input logic [31:0] a, input int lat, input bit inv_last,
                       input bit inv_mid, input bit do_inv);
    bit h;
    lookup(a, do_inv, 1'b0, h);
    if (!h) refill(a, lat, inv_last, inv_mid);
  endtask

  initial begin
    bit h;
    logic [25:0] t;
    logic [31:0] a;

    reset = 1'b1; pc = 32'h40; inv = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
    model_clear();
    mcount = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 32'(icache_stall), 32'd1);
    chk("rst_instr", instr_f, 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_miss_count", 32'(miss_count), 32'd0);

    // Cold miss with a three-cycle memory
    stall_seen = 0;
    lookup(32'h40, 1'b0, 1'b0, h);
    chk("cold_is_miss", 32'(h), 32'd0);
    refill(32'h40, 3, 1'b0, 1'b0);
    lookup(32'h40, 1'b0, 1'b0, h);
    chk("cold_instr", instr_f, 32'h2008_0005);
    chk("cold_stall_cycles", 32'(stall_seen), 32'd5);
    chk("cold_miss_count", 32'(miss_count), 32'd1);

    // Unaligned pc hits the same word
    lookup(32'h43, 1'b0, 1'b0, h);
    chk("unaligned_instr", instr_f, 32'h2008_0005);

    // Conflict eviction on the same index
    fetch(32'h80, 2, 1'b0, 1'b0, 1'b0);
    fetch(32'h40, 1, 1'b0, 1'b0, 1'b0);
    lookup(32'h40, 1'b0, 1'b0, h);
    chk("conflict_miss_count", 32'(miss_count), 32'd3);

    // inv on the completing edge leaves the line invalid
    fetch(32'h100, 2, 1'b1, 1'b0, 1'b0);
    lookup(32'h100, 1'b0, 1'b0, h);
    chk("inv_fill_remiss", 32'(h), 32'd0);
    refill(32'h100, 0, 1'b0, 1'b0);
    lookup(32'h100, 1'b0, 1'b0, h);

    // Reset in the middle of a refill
    lookup(32'h200, 1'b0, 1'b0, h);
    @(negedge clk);
    pc = 32'h200; inv = 1'b0; mem_ready = 1'b0;
    #1;
    chk("midrst_req_before", 32'(mem_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_addr", mem_addr, 32'h0);
    chk("midrst_stall", 32'(icache_stall), 32'd1);
    chk("midrst_count", 32'(miss_count), 32'd0);
    model_clear();
    mcount = 0;
    lookup(32'h200, 1'b0, 1'b1, h);
    chk("midrst_late_ready_miss", 32'(h), 32'd0);
    refill(32'h200, 1, 1'b0, 1'b0);
    lookup(32'h200, 1'b0, 1'b0, h);

    // Saturation of the narrow counter
    for (int i = 0; i < 5; i++) fetch(32'h300 + 32'(i * 4), 0, 1'b0, 1'b0, 1'b0);
    lookup(32'h300, 1'b0, 1'b0, h);
    chk("sat_count", 32'(miss_count2), 32'd3);
    chk("wide_count", 32'(miss_count), 32'd6);

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      t = ($urandom_range(0, 3) == 3) ? 26'h3FF_FFFF : 26'($urandom_range(0, 2));
      a = {t, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      fetch(a, int'($urandom_range(0, 4)), $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
    end
    lookup(32'h0, 1'b0, 1'b0, h);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_fetch.md
ICACHE_FETCH -- requirements
Module: icache_fetch

Interface
REQ-001 The block SHALL have parameter NUM_LINES, default 16, number of direct-mapped one-word lines (power of 2, 2..64).
REQ-002 The block SHALL have parameter MISS_CNT_W, default 16, width of the miss counter.
REQ-003 The block SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port pc, input, 32, fetch address from the core PC register.
REQ-006 The block SHALL have port instr_f, output, 32, fetched instruction to the fetch-to-decode register.
REQ-007 The block SHALL have port icache_stall, output, 1, high while instr_f is not valid; OR'd into core stall_f/stall_d.
REQ-008 The block SHALL have port inv, input, 1, single-cycle pulse invalidating all lines.
REQ-009 The block SHALL have port mem_req, output, 1, refill request to main memory.
REQ-010 The block SHALL have port mem_addr, output, 32, word-aligned refill address.
REQ-011 The block SHALL have port mem_rdata, input, 32, refill data, valid when mem_ready is high.
REQ-012 The block SHALL have port mem_ready, input, 1, one-cycle refill completion strobe.
REQ-013 The block SHALL have port miss_count, output, MISS_CNT_W, saturating count of misses since reset.

Function
REQ-014 Address split: byte offset pc[1:0] ignored; index = pc[IW+1:2], IW = log2(NUM_LINES); tag = pc[31:IW+2].
REQ-015 Each line SHALL hold a valid bit, a tag, and a 32-bit word.
REQ-016 The FSM SHALL have exactly two states, IDLE and REFILL.
REQ-017 In IDLE, hit = valid[index] and tag match; on hit, instr_f = line word and icache_stall = 0 in the same cycle (combinational lookup, zero-cycle latency).
REQ-018 In IDLE on miss, icache_stall = 1, instr_f = 0 (NOP), the word-aligned pc is captured into a miss-address register, miss_count is incremented, and the FSM moves to REFILL on the next edge.
REQ-019 In REFILL, mem_req = 1, mem_addr = captured address, icache_stall = 1, instr_f = 0; mem_req SHALL stay high until mem_ready is sampled high.
REQ-020 On the edge where mem_ready = 1 in REFILL, the line at the captured index SHALL be written with mem_rdata, the captured tag, and valid = 1, and the FSM SHALL return to IDLE.
REQ-021 A miss-to-hit round trip SHALL take exactly (memory latency + 2) cycles of stall: the miss cycle, the REFILL cycles, and then a hit in IDLE.
REQ-022 mem_ready outside REFILL SHALL be ignored.
REQ-023 In IDLE, mem_req = 0 and mem_addr = 0.
REQ-024 Any inv pulse SHALL clear all valid bits on that edge.
REQ-025 If inv and a refill completion occur on the same edge, inv SHALL win: the filled line is left invalid, the FSM returns to IDLE, and the next lookup misses again.
REQ-026 An inv pulse in REFILL SHALL NOT abort the outstanding request.
REQ-027 miss_count SHALL saturate at all-ones and SHALL NOT wrap.
REQ-028 A pc change while in REFILL (not expected, because stall holds the PC) SHALL NOT affect the captured address; the refill completes to the captured line.

Reset
REQ-029 Asserting reset SHALL immediately set state to IDLE, clear all valid bits and the miss-address register, set miss_count = 0, and deassert mem_req.
REQ-030 Reset asserted mid-refill SHALL abandon the request; a mem_ready arriving after reset SHALL be ignored.
REQ-031 Output values under reset SHALL be: icache_stall = 1 (any pc misses, since all lines are invalid), instr_f = 0, mem_req = 0, mem_addr = 0, miss_count = 0.
REQ-032 Tag and data arrays SHALL NOT require reset.

Structure
REQ-033 A shared package icache_pkg SHALL hold the state enum (IDLE, REFILL) and the constant NOP_INSTR = 32'h0000_0000.
REQ-034 The tag/valid/data storage SHALL be a single sub-module, icache_array, with one combinational read port, one write port, and a flash-clear input.
REQ-035 The FSM, miss-address register, and counter SHALL reside in icache_fetch.

Verification
REQ-036 Cold miss: reset, pc=0x0000_0040, memory returns 0x2008_0005 after 3 cycles -> stall high for 5 cycles total, mem_addr=0x40, then instr_f=0x2008_0005 with stall low, miss_count=1.
REQ-037 Conflict eviction: fill 0x40, then pc=0x0000_0080 (same index, NUM_LINES=16) -> miss; afterwards pc=0x40 misses again, miss_count=3.
REQ-038 Simultaneous inv and mem_ready at pc=0x100 -> line not valid; the next IDLE cycle misses again and mem_req reasserts with mem_addr=0x100.
REQ-039 Reset mid-refill: assert reset while mem_req=1 -> mem_req=0 immediately; a late mem_ready is ignored; the next lookup is a miss.
REQ-040 Saturation: MISS_CNT_W=2, 5 distinct misses -> miss_count holds 3.
REQ-041 Unaligned pc=0x0000_0043 after a fill of 0x40 -> hit, returns the same word as for 0x40.
